// File: rtl/ins_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// State encoding, reset PC default, JAL predecode helper.
package ins_fetch_queue_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RST_PC_DEF = 32'h0;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] jal_imm(input logic [ILEN-1:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction/PC FIFO with push, pop and single-cycle clear.
// Head entry is presented from storage registers, zero when empty.
module fetch_fifo
    import ins_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_in,
    input  logic                       rstn_in,
    input  logic                       push,
    input  logic [ILEN-1:0]            push_ins,
    input  logic [XLEN-1:0]            push_pc,
    input  logic                       pop,
    input  logic                       clear,
    output logic [$clog2(DEPTH):0]     count,
    output logic [ILEN-1:0]            head_ins,
    output logic [XLEN-1:0]            head_pc
);

    localparam int AW = $clog2(DEPTH);

    logic [ILEN-1:0] ins_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q  [DEPTH];
    logic [AW:0]     head_q, head_d;
    logic [AW:0]     tail_q, tail_d;
    logic [AW:0]     count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk_in) begin
        if (push && !clear) begin
            ins_mem_q[tail_q[AW-1:0]] <= push_ins;
            pc_mem_q[tail_q[AW-1:0]]  <= push_pc;
        end
    end

    assign count    = count_q;
    assign head_ins = (count_q != '0) ? ins_mem_q[head_q[AW-1:0]] : '0;
    assign head_pc  = (count_q != '0) ? pc_mem_q[head_q[AW-1:0]]  : '0;

endmodule

// File: rtl/ins_fetch_queue.sv
// Fetch front end: PC owner, single-outstanding icache requester, FIFO.
// Define FETCH_PREDECODE_JAL_EN to follow JAL targets at push time.
module ins_fetch_queue
    import ins_fetch_queue_pkg::*;
#(
    parameter int              DEPTH  = 4,
    parameter logic [XLEN-1:0] RST_PC = RST_PC_DEF
) (
    input  logic            clk_in,
    input  logic            rstn_in,
    input  logic            rdy_in,
    output logic            icache_req,
    output logic [XLEN-1:0] icache_addr,
    input  logic            icache_gnt,
    input  logic            icache_rvalid,
    input  logic [ILEN-1:0] icache_rdata,
    input  logic            stall_in,
    input  logic            jump_flg,
    input  logic [XLEN-1:0] jump_pc,
    output logic            ins_flg,
    output logic [ILEN-1:0] ins,
    output logic [XLEN-1:0] pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pc_step;
    logic            live_q;
    logic [CW-1:0]   count;
    logic            push, pop, clear;

    always_comb begin
`ifdef FETCH_PREDECODE_JAL_EN
        if (icache_rdata[6:0] == OPC_JAL) pc_step = jal_imm(icache_rdata);
        else                              pc_step = 32'd4;
`else
        pc_step = 32'd4;
`endif
    end

    // Request stays low in reset and until the first edge after release.
    assign icache_req = live_q & rdy_in & ~jump_flg
                      & (state_q == ST_IDLE) & (count < CW'(DEPTH));
    assign icache_addr = fetch_pc_q;
    assign ins_flg = rdy_in & ~jump_flg & ~stall_in & (count != '0);
    assign pop = ins_flg;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        clear      = 1'b0;
        if (rdy_in) begin
            if (jump_flg) begin
                fetch_pc_d = jump_pc;
                clear      = 1'b1;
                unique case (state_q)
                    ST_WAIT: state_d = icache_rvalid ? ST_IDLE : ST_DROP;
                    ST_DROP: state_d = icache_rvalid ? ST_IDLE : ST_DROP;
                    default: state_d = ST_IDLE;
                endcase
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (icache_req && icache_gnt) state_d = ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (icache_rvalid) begin
                            push       = 1'b1;
                            fetch_pc_d = fetch_pc_q + pc_step;
                            state_d    = ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (icache_rvalid) state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RST_PC;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            live_q     <= 1'b1;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_in   (clk_in),
        .rstn_in  (rstn_in),
        .push     (push),
        .push_ins (icache_rdata),
        .push_pc  (fetch_pc_q),
        .pop      (pop),
        .clear    (clear),
        .count    (count),
        .head_ins (ins),
        .head_pc  (pc)
    );

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Directed bench for ins_fetch_queue with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are checked before the next.
module tb_ins_fetch_queue;

    logic        clk_in = 1'b0;
    logic        rstn_in;
    logic        rdy_in;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_gnt;
    logic        icache_rvalid;
    logic [31:0] icache_rdata;
    logic        stall_in;
    logic        jump_flg;
    logic [31:0] jump_pc;
    logic        ins_flg;
    logic [31:0] ins;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    ins_fetch_queue dut (
        .clk_in        (clk_in),
        .rstn_in       (rstn_in),
        .rdy_in        (rdy_in),
        .icache_req    (icache_req),
        .icache_addr   (icache_addr),
        .icache_gnt    (icache_gnt),
        .icache_rvalid (icache_rvalid),
        .icache_rdata  (icache_rdata),
        .stall_in      (stall_in),
        .jump_flg      (jump_flg),
        .jump_pc       (jump_pc),
        .ins_flg       (ins_flg),
        .ins           (ins),
        .pc            (pc)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rdy_in        = 1'b1;
        icache_gnt    = 1'b0;
        icache_rvalid = 1'b0;
        icache_rdata  = 32'h0;
        stall_in      = 1'b0;
        jump_flg      = 1'b0;
        jump_pc       = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn_in = 1'b0;
        tick();
        tick();
        rstn_in = 1'b1;
        tick();
    endtask

    // Grant now, respond `lat` cycles later with `word`.
    task automatic fetch_one(input logic [31:0] word, input int lat);
        icache_gnt = 1'b1;
        tick();
        icache_gnt = 1'b0;
        for (int i = 1; i < lat; i++) tick();
        icache_rvalid = 1'b1;
        icache_rdata  = word;
        tick();
        icache_rvalid = 1'b0;
        icache_rdata  = 32'h0;
        #1;
    endtask

    task automatic jump_to(input logic [31:0] target);
        jump_flg = 1'b1;
        jump_pc  = target;
        tick();
        jump_flg = 1'b0;
        jump_pc  = 32'h0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn_in = 1'b0;
        #1;
        tick();
        checks++;
        if (icache_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_req got %b exp 0", icache_req);
        end
        checks++;
        if (icache_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_addr got %h exp 0", icache_addr);
        end
        checks++;
        if ({ins_flg, ins, pc} !== 65'h0) begin
            errors++;
            $display("FAIL rst_out got %b %h %h exp 0", ins_flg, ins, pc);
        end
        rstn_in = 1'b1;
        #1;
        checks++;
        if (icache_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_rel_req got %b exp 0", icache_req);
        end
        tick();
        checks++;
        if (icache_req !== 1'b1) begin
            errors++;
            $display("FAIL live_req got %b exp 1", icache_req);
        end
    endtask

    task automatic test_basic();
        do_reset();
        fetch_one(32'h00500093, 2);
        checks++;
        if (ins_flg !== 1'b1 || ins !== 32'h00500093 || pc !== 32'h0) begin
            errors++;
            $display("FAIL basic_out got %b %h %h exp 1 00500093 0",
                     ins_flg, ins, pc);
        end
        checks++;
        if (icache_addr !== 32'h4) begin
            errors++;
            $display("FAIL basic_addr got %h exp 4", icache_addr);
        end
        tick();
        checks++;
        if (ins_flg !== 1'b0 || ins !== 32'h0) begin
            errors++;
            $display("FAIL basic_pop got %b %h exp 0 0", ins_flg, ins);
        end
    endtask

    task automatic test_fill();
        logic [31:0] exp_pc;
        logic [31:0] word;
        do_reset();
        stall_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(i * 4);
            checks++;
            if (icache_req !== 1'b1 || icache_addr !== exp_pc) begin
                errors++;
                $display("FAIL fill_req%0d got %b %h exp 1 %h",
                         i, icache_req, icache_addr, exp_pc);
            end
            fetch_one(32'hA000_0000 + 32'(i), 1);
        end
        tick();
        tick();
        checks++;
        if (icache_req !== 1'b0 || ins_flg !== 1'b0) begin
            errors++;
            $display("FAIL full_req got %b %b exp 0 0", icache_req, ins_flg);
        end
        stall_in = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(i * 4);
            word   = 32'hA000_0000 + 32'(i);
            checks++;
            if (ins_flg !== 1'b1 || pc !== exp_pc || ins !== word) begin
                errors++;
                $display("FAIL drain%0d got %b %h %h exp 1 %h %h",
                         i, ins_flg, pc, ins, exp_pc, word);
            end
            tick();
        end
        checks++;
        if (ins_flg !== 1'b0 || pc !== 32'h0) begin
            errors++;
            $display("FAIL drained got %b %h exp 0 0", ins_flg, pc);
        end
    endtask

    task automatic test_flush_wait();
        do_reset();
        icache_gnt = 1'b1;
        tick();
        icache_gnt = 1'b0;
        jump_flg = 1'b1;
        jump_pc  = 32'h1000;
        #1;
        checks++;
        if (icache_req !== 1'b0 || ins_flg !== 1'b0) begin
            errors++;
            $display("FAIL fw_jump got %b %b exp 0 0", icache_req, ins_flg);
        end
        tick();
        jump_flg = 1'b0;
        jump_pc  = 32'h0;
        #1;
        checks++;
        if (icache_req !== 1'b0 || icache_addr !== 32'h1000) begin
            errors++;
            $display("FAIL fw_drop got %b %h exp 0 1000",
                     icache_req, icache_addr);
        end
        icache_rvalid = 1'b1;
        icache_rdata  = 32'hDEAD_BEEF;
        tick();
        icache_rvalid = 1'b0;
        #1;
        checks++;
        if (ins_flg !== 1'b0 || ins !== 32'h0 || icache_req !== 1'b1
            || icache_addr !== 32'h1000) begin
            errors++;
            $display("FAIL fw_after got %b %h %b %h exp 0 0 1 1000",
                     ins_flg, ins, icache_req, icache_addr);
        end
        fetch_one(32'h0000_0013, 1);
        checks++;
        if (ins_flg !== 1'b1 || pc !== 32'h1000 || ins !== 32'h13) begin
            errors++;
            $display("FAIL fw_first got %b %h %h exp 1 1000 13",
                     ins_flg, pc, ins);
        end
    endtask

    task automatic test_flush_rvalid();
        do_reset();
        stall_in = 1'b1;
        fetch_one(32'h11, 1);
        fetch_one(32'h22, 1);
        icache_gnt = 1'b1;
        tick();
        icache_gnt    = 1'b0;
        stall_in      = 1'b0;
        jump_flg      = 1'b1;
        jump_pc       = 32'h2000;
        icache_rvalid = 1'b1;
        icache_rdata  = 32'h33;
        #1;
        checks++;
        if (ins_flg !== 1'b0) begin
            errors++;
            $display("FAIL fr_flg got %b exp 0", ins_flg);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ins_flg !== 1'b0 || ins !== 32'h0 || pc !== 32'h0) begin
            errors++;
            $display("FAIL fr_empty got %b %h %h exp 0 0 0", ins_flg, ins, pc);
        end
        checks++;
        if (icache_req !== 1'b1 || icache_addr !== 32'h2000) begin
            errors++;
            $display("FAIL fr_idle got %b %h exp 1 2000",
                     icache_req, icache_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        jump_to(32'hFFFF_FFFC);
        checks++;
        if (icache_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_jump got %h exp fffffffc", icache_addr);
        end
        fetch_one(32'h13, 1);
        checks++;
        if (pc !== 32'hFFFF_FFFC || icache_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap got %h %h exp fffffffc 0", pc, icache_addr);
        end
    endtask

    task automatic test_jal();
        logic [31:0] exp_addr;
`ifdef FETCH_PREDECODE_JAL_EN
        exp_addr = 32'h30;
`else
        exp_addr = 32'h24;
`endif
        do_reset();
        jump_to(32'h20);
        fetch_one(32'h0100_006F, 1);
        checks++;
        if (ins_flg !== 1'b1 || pc !== 32'h20 || ins !== 32'h0100006F) begin
            errors++;
            $display("FAIL jal_out got %b %h %h exp 1 20 0100006f",
                     ins_flg, pc, ins);
        end
        checks++;
        if (icache_addr !== exp_addr) begin
            errors++;
            $display("FAIL jal_addr got %h exp %h", icache_addr, exp_addr);
        end
    endtask

    task automatic test_rdy_and_midreset();
        do_reset();
        stall_in = 1'b1;
        fetch_one(32'h55, 1);
        stall_in   = 1'b0;
        rdy_in     = 1'b0;
        icache_gnt = 1'b1;
        #1;
        checks++;
        if (icache_req !== 1'b0 || ins_flg !== 1'b0) begin
            errors++;
            $display("FAIL rdy_low got %b %b exp 0 0", icache_req, ins_flg);
        end
        tick();
        tick();
        rdy_in     = 1'b1;
        icache_gnt = 1'b0;
        #1;
        checks++;
        if (ins_flg !== 1'b1 || pc !== 32'h0 || ins !== 32'h55
            || icache_req !== 1'b1 || icache_addr !== 32'h4) begin
            errors++;
            $display("FAIL rdy_hold got %b %h %h %b %h exp 1 0 55 1 4",
                     ins_flg, pc, ins, icache_req, icache_addr);
        end
        tick();
        icache_gnt = 1'b1;
        tick();
        icache_gnt = 1'b0;
        rstn_in    = 1'b0;
        #1;
        checks++;
        if (icache_req !== 1'b0 || icache_addr !== 32'h0) begin
            errors++;
            $display("FAIL midrst got %b %h exp 0 0", icache_req, icache_addr);
        end
        rstn_in = 1'b1;
        tick();
        icache_rvalid = 1'b1;
        icache_rdata  = 32'h77;
        tick();
        icache_rvalid = 1'b0;
        #1;
        checks++;
        if (ins_flg !== 1'b0 || ins !== 32'h0 || icache_req !== 1'b1) begin
            errors++;
            $display("FAIL stray got %b %h %b exp 0 0 1",
                     ins_flg, ins, icache_req);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_flush_wait();
        test_flush_rvalid();
        test_wrap();
        test_jal();
        test_rdy_and_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ins_fetch_queue.md
# ins_fetch_queue

Instruction fetch front end: owns the fetch PC, issues one word request at a time to the instruction cache, and buffers returned words with their PCs in a small FIFO. Supplies the `ins_flg`/`ins`/`pc` triple consumed by the instruction decoder. A flush from the commit/branch path redirects fetch and discards all buffered and in-flight instructions.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `RST_PC`, default 32'h0: fetch PC after reset.
- `clk_in` in 1: clock. One clock domain.
- `rstn_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: global ready; when low, all state holds and `icache_req`=0, `ins_flg`=0.
- `icache_req` out 1: fetch request valid.
- `icache_addr` out 32: word address of request (always `fetch_pc`).
- `icache_gnt` in 1: request accepted this cycle.
- `icache_rvalid` in 1: response word valid; one response per grant, ≥1 cycle after grant.
- `icache_rdata` in 32: response instruction word.
- `stall_in` in 1: downstream cannot accept this cycle.
- `jump_flg` in 1: flush/redirect.
- `jump_pc` in 32: redirect target.
- `ins_flg` out 1: instruction delivered this cycle (pop).
- `ins` out 32: head instruction; 0 when FIFO empty.
- `pc` out 32: head PC; 0 when FIFO empty.

## Operation
- Registers: `fetch_pc`, FIFO (`ins`,`pc` per entry), head/tail pointers (log2(DEPTH)+1 bits, wrap naturally), `count`, FSM state.
- FSM states: IDLE, WAIT, DROP. Reset → IDLE.
- IDLE: `icache_req` = (count < DEPTH) & ~jump_flg. On `icache_gnt` → WAIT. Request and address may change/withdraw before grant.
- WAIT: on `icache_rvalid`: push {`icache_rdata`, `fetch_pc`}; `fetch_pc` += 4; → IDLE.
- DROP: on `icache_rvalid`: discard word, no push, → IDLE. No request issued in WAIT or DROP.
- Pop: `ins_flg` = (count ≠ 0) & ~stall_in & ~jump_flg & rdy_in; head advances on pop.
- Flush (`jump_flg`=1): `fetch_pc` ← `jump_pc`; head=tail, count=0; no pop, no push. State: IDLE→IDLE; WAIT without rvalid→DROP; WAIT with rvalid same cycle→IDLE (word discarded); DROP→DROP unless rvalid (→IDLE).
- Simultaneous push and pop: count unchanged. Push into full FIFO cannot occur (request gated on count<DEPTH; pops only free space).
- PC arithmetic: 32-bit, wraps modulo 2^32 (0xFFFF_FFFC + 4 → 0). Low two bits of `jump_pc` passed through unchanged.

## Timing
- Reset values: `icache_req`=0 until first clock after release, `icache_addr`=RST_PC, `ins_flg`=0, `ins`=0, `pc`=0, count=0, state IDLE.
- Reset asserted mid-operation: immediate return to reset values; a later stray `icache_rvalid` in IDLE is ignored.
- Latency: rvalid in cycle t → entry at head, `ins_flg` possible in t+1. Best-case throughput one instruction per (grant-to-rvalid + 1) cycles.
- `ins`/`pc` are registered FIFO reads; `ins_flg` combinational from count, `stall_in`, `jump_flg`, `rdy_in`.
- `icache_rvalid` in IDLE is a protocol error; ignored.

## Configuration
- `FETCH_PREDECODE_JAL_EN`: when defined, on push of a word with opcode 7'b1101111 (JAL), `fetch_pc` ← `fetch_pc` + J-immediate (sign-extended {ins[31],ins[19:12],ins[20],ins[30:21],1'b0}) instead of +4; the JAL itself is still pushed with its own PC. When undefined, `fetch_pc` always advances by 4. Flush overrides either.

## Structure
- Shared package: FSM state encoding, `RST_PC` default, JAL opcode constant, instruction/PC width constants.
- One sub-module: `fetch_fifo` (parameterised DEPTH, push/pop/clear, count, head data out); FSM and PC logic stay in the top.

## Test plan
- Reset, icache grants same cycle, rvalid 2 cycles later with 0x00500093 → `ins_flg`=1, `ins`=0x00500093, `pc`=0 the cycle after rvalid; next `icache_addr`=4.
- `stall_in`=1 throughout, responses always ready → exactly DEPTH=4 pushes (PCs 0,4,8,C), then `icache_req` stays 0; release stall → pops in order 0,4,8,C.
- `jump_flg` with `jump_pc`=0x1000 while in WAIT → in-flight rvalid discarded, FIFO empty, next request address 0x1000, first delivered `pc`=0x1000.
- `jump_flg` in same cycle as rvalid and non-empty FIFO with `stall_in`=0 → `ins_flg`=0, no push, count=0, state IDLE.
- `fetch_pc`=0xFFFFFFFC, response received → next `icache_addr`=0.
- With `FETCH_PREDECODE_JAL_EN`, word 0x0100006F at PC 0x20 → JAL delivered with `pc`=0x20, next request address 0x30; without macro, 0x24.
